// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the time-shared "101" detector scheduler.
// Holds the scheduler state encoding, requester IDs and detector latency.
package seq_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam logic REQ0    = 1'b0;
    localparam logic REQ1    = 1'b1;
    localparam int   DET_LAT = 1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: requester ptr wins if asking, else the other one.
// Purely combinational; the pointer register belongs to the parent.
module rr_arb2
    import seq_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    // Grant selection with pointer priority
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req[ptr]) begin
            gnt = onehot2(ptr);
        end else if (req[~ptr]) begin
            gnt = onehot2(~ptr);
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Arbitrates two requesters onto one serial "101" Mealy detector, streams each
// word MSB-first into it and returns the hit count with the requester ID.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [CNT_W-1:0] rsp_count,
    input  logic             rsp_ready,
    output logic             det_in,
    output logic             det_clr,
    input  logic             det_out
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic               rsp_id_q,  rsp_id_d;
    logic               rr_ptr_q,  rr_ptr_d;
    logic               arb_en_s;
    logic [1:0]         gnt_s;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (arb_en_s),
        .gnt (gnt_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            hit_cnt_q <= '0;
            rsp_cnt_q <= '0;
            rsp_id_q  <= 1'b0;
            rr_ptr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            hit_cnt_q <= hit_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            rsp_id_q  <= rsp_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        hit_cnt_d = hit_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        rsp_id_d  = rsp_id_q;
        rr_ptr_d  = rr_ptr_q;
        arb_en_s  = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        det_in    = 1'b0;
        det_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so no acceptance pulse leaks while held in reset
                arb_en_s  = reset;
                req_ready = gnt_s;
                if (gnt_s != 2'b00) begin
                    shreg_d   = gnt_s[1] ? req_data1 : req_data0;
                    rsp_id_d  = gnt_s[1] ? REQ1 : REQ0;
                    rr_ptr_d  = ~gnt_s[1];
                    hit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = CLEAR;
                end else begin
                    state_d   = IDLE;
                end
            end
            CLEAR: begin
                det_clr = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                det_in  = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                // det_out lags the serial input, so the first SHIFT cycle reflects the cleared input
                if ((idx_q >= IDX_W'(DET_LAT)) && det_out) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SHIFT;
                end
            end
            DRAIN: begin
                if (det_out) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    rsp_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    rsp_cnt_d = hit_cnt_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: models the external "101" detector and checks
// results against substring counts and round-robin grant expectations.
module tb_seq_detect_sched;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0, req_data1;
    logic [1:0]       req_ready;
    logic             rsp_valid, rsp_id, rsp_ready;
    logic [CNT_W-1:0] rsp_count;
    logic             det_in, det_clr, det_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_detect_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready),
        .det_in    (det_in),
        .det_clr   (det_clr),
        .det_out   (det_out)
    );

    // External detector: registered input plus two bits of history, Mealy output
    logic       det_in_r;
    logic [1:0] det_hist;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_in_r <= 1'b0;
            det_hist <= 2'b00;
        end else if (det_clr) begin
            det_in_r <= 1'b0;
            det_hist <= 2'b00;
        end else begin
            det_in_r <= det_in;
            det_hist <= {det_hist[0], det_in_r};
        end
    end
    assign det_out = (det_hist == 2'b10) && det_in_r;

    function automatic logic [CNT_W-1:0] count101(input logic [WIDTH-1:0] w);
        int c = 0;
        for (int i = WIDTH - 1; i >= 2; i--)
            if (w[i] && !w[i-1] && w[i-2]) c++;
        return CNT_W'(c);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req_valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Submit one word, record handshake timing and response (no checking here)
    task automatic run_job(input int who, input logic [WIDTH-1:0] w,
                           output logic [1:0] rdy, output logic [1:0] rdy_next,
                           output logic clr1, output int lat, output logic id,
                           output logic [CNT_W-1:0] cnt, output logic tmo);
        int n;
        tmo = 1'b0; rdy = 2'b00; rdy_next = 2'b00; clr1 = 1'b0; lat = 0; id = 1'b0; cnt = '0;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (who == 0) req_data0 = w; else req_data1 = w;
        req_valid = (who == 0) ? 2'b01 : 2'b10;
        #1; n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        if (req_ready == 2'b00) begin tmo = 1'b1; req_valid = 2'b00; return; end
        rdy = req_ready;
        @(negedge clk);
        req_valid = 2'b00; req_data0 = 8'($urandom); req_data1 = 8'($urandom);
        #1;
        rdy_next = req_ready; clr1 = det_clr; lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); #1; lat++; end
        if (!rsp_valid) begin tmo = 1'b1; return; end
        id = rsp_id; cnt = rsp_count;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 2'b11; req_data0 = 8'hAA; req_data1 = 8'h55; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_count, det_in, det_clr} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%b cnt=%0d in=%b clr=%b, need all 0",
                     req_ready, rsp_valid, rsp_id, rsp_count, det_in, det_clr);
        end
        req_valid = 2'b00;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_single();
        logic [1:0] rdy, rdy_next; logic clr1, id, tmo; int lat; logic [CNT_W-1:0] cnt;
        run_job(0, 8'b1010_1010, rdy, rdy_next, clr1, lat, id, cnt, tmo);
        tests_run++;
        if (tmo !== 1'b0) begin tests_failed++; $display("FAIL single_timeout: got %b need 0", tmo); end
        tests_run++;
        if (rdy !== 2'b01 || rdy_next !== 2'b00) begin
            tests_failed++; $display("FAIL single_ready: got %b then %b, need 01 then 00", rdy, rdy_next);
        end
        tests_run++;
        if (clr1 !== 1'b1) begin tests_failed++; $display("FAIL single_clr: det_clr at T+1 got %b need 1", clr1); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL single_latency: got T+%0d need T+11", lat); end
        tests_run++;
        if (id !== 1'b0 || cnt !== 4'd3) begin
            tests_failed++; $display("FAIL single_rsp: got id=%b cnt=%0d need id=0 cnt=3", id, cnt);
        end
    endtask

    task automatic test_req1_patterns();
        logic [WIDTH-1:0] pats [3] = '{8'b1010_0101, 8'h00, 8'hFF};
        logic [CNT_W-1:0] exps [3] = '{4'd2, 4'd0, 4'd0};
        logic [1:0] rdy, rdy_next; logic clr1, id, tmo; int lat; logic [CNT_W-1:0] cnt;
        for (int k = 0; k < 3; k++) begin
            run_job(1, pats[k], rdy, rdy_next, clr1, lat, id, cnt, tmo);
            tests_run++;
            if (tmo !== 1'b0 || rdy !== 2'b10 || id !== 1'b1 || cnt !== exps[k] || lat !== 11) begin
                tests_failed++;
                $display("FAIL req1_pattern %h: got tmo=%b rdy=%b id=%b cnt=%0d lat=%0d need tmo=0 rdy=10 id=1 cnt=%0d lat=11",
                         pats[k], tmo, rdy, id, cnt, lat, exps[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] rdy, rdy_next; logic clr1, id, tmo; int lat; logic [CNT_W-1:0] cnt;
        int who; logic [WIDTH-1:0] w;
        for (int k = 0; k < 16; k++) begin
            who = int'($urandom_range(1, 0));
            w   = 8'($urandom);
            run_job(who, w, rdy, rdy_next, clr1, lat, id, cnt, tmo);
            tests_run++;
            if (tmo !== 1'b0 || id !== 1'(who) || cnt !== count101(w) || lat !== 11 || clr1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_job %0d w=%h: got tmo=%b id=%b cnt=%0d lat=%0d clr=%b need id=%0d cnt=%0d lat=11 clr=1",
                         k, w, tmo, id, cnt, lat, clr1, who, count101(w));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ptr, exp_g; int n;
        do_reset();
        @(negedge clk);
        req_data0 = 8'b1011_0101; req_data1 = 8'h00; rsp_ready = 1'b1; req_valid = 2'b11;
        exp_ptr = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
            exp_g = exp_ptr; exp_ptr = ~exp_g;
            tests_run++;
            if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
                tests_failed++; $display("FAIL b2b_grant %0d: got %b need %b", j, req_ready, exp_g ? 2'b10 : 2'b01);
            end
            @(negedge clk); #1; n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_g ||
                rsp_count !== (exp_g ? count101(8'h00) : count101(8'b1011_0101))) begin
                tests_failed++;
                $display("FAIL b2b_rsp %0d: got v=%b id=%b cnt=%0d need v=1 id=%b cnt=%0d", j, rsp_valid, rsp_id,
                         rsp_count, exp_g, exp_g ? count101(8'h00) : count101(8'b1011_0101));
            end
            if (j == 3) req_valid = 2'b00;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_data0 = 8'b1010_1010; req_valid = 2'b01; rsp_ready = 1'b0;
        #1; n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req_valid = 2'b10; req_data1 = 8'b1010_0101;
        #1; n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_count !== 4'd3) begin
            tests_failed++; $display("FAIL bp_first_rsp: got v=%b id=%b cnt=%0d need 1/0/3", rsp_valid, rsp_id, rsp_count);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_count !== 4'd3 || req_ready !== 2'b00) begin
                tests_failed++;
                $display("FAIL bp_hold %0d: got v=%b id=%b cnt=%0d rdy=%b need 1/0/3/00", c, rsp_valid, rsp_id,
                         rsp_count, req_ready);
            end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        tests_run++;
        if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL bp_handshake_cycle: rdy got %b need 00", req_ready); end
        @(negedge clk); #1;
        tests_run++;
        if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_pending_accept: got rdy=%b v=%b need rdy=10 v=0", req_ready, rsp_valid);
        end
        @(negedge clk); req_valid = 2'b00; #1; n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_count !== 4'd2) begin
            tests_failed++; $display("FAIL bp_second_rsp: got v=%b id=%b cnt=%0d need 1/1/2", rsp_valid, rsp_id, rsp_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midjob();
        logic [1:0] rdy, rdy_next; logic clr1, id, tmo; int lat, n; logic [CNT_W-1:0] cnt;
        @(negedge clk);
        req_data0 = 8'b1010_1010; req_valid = 2'b01; rsp_ready = 1'b1;
        #1; n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_count, det_in, det_clr} !== 10'd0) begin
            tests_failed++;
            $display("FAIL midjob_reset_outputs: got rdy=%b v=%b id=%b cnt=%0d in=%b clr=%b need all 0",
                     req_ready, rsp_valid, rsp_id, rsp_count, det_in, det_clr);
        end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); reset = 1'b1;
        run_job(0, 8'b1010_1010, rdy, rdy_next, clr1, lat, id, cnt, tmo);
        tests_run++;
        if (tmo !== 1'b0 || id !== 1'b0 || cnt !== 4'd3 || lat !== 11) begin
            tests_failed++;
            $display("FAIL midjob_rerun: got tmo=%b id=%b cnt=%0d lat=%0d need 0/0/3/11", tmo, id, cnt, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_req1_patterns();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
